regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the five-stage pipeline, with synchronous write, optional write-to-read bypass, optional hardwired-zero register and a per-register pending-write scoreboard. Decode issues the destination register to the scoreboard and writeback commits data, so hazard logic can read a busy flag alongside each operand. Sits between ID (reads, issue) and WB (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1: same-cycle write data forwarded to matching read ports
INIT_MODE, 0, 0: reset clears all registers; 1: reg[i] = 10*i+1 for i < DEPTH-2, reg[DEPTH-2] = 0, reg[DEPTH-1] = 10
CNT_W, 2, width of each pending-write counter (max 2**CNT_W-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  1: the addressed register has an uncommitted pending write
wr_en  in  1  writeback commit
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  an instruction with a destination register was issued
iss_addr  in  ADDR_W  issued destination register
ovf  out  1  sticky: an issue hit a saturated counter

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: array loaded per INIT_MODE; all pending counters cleared to 0; ovf cleared to 0. With ZERO_REG=1, reg[0] stays 0 regardless of INIT_MODE. Reset overrides wr_en and iss_en in the same cycle.
- Read: rd_data[p] is taken combinationally from the array with zero-cycle latency. ZERO_REG=1 and address 0 gives 0.
- Bypass (BYPASS=1): if wr_en is high, wr_addr equals rd_addr[p], and the address is not a ZERO_REG-masked register 0, then rd_data[p] = wr_data. BYPASS=0 returns the old array value until the next cycle.
- Write: on the rising edge, if wr_en and not reset and not (ZERO_REG and wr_addr==0), then reg[wr_addr] <= wr_data. Exactly one write port; there is no write-write conflict.
- Scoreboard: one CNT_W-bit counter cnt[r] per register. Next-cycle rules for each r:
  - iss hits r only: cnt+1; if cnt is already at max, it holds and ovf <= 1.
  - write hits r only: cnt-1 when cnt>0; when cnt==0 it stays 0 (an untracked write is legal and raises no error).
  - iss and write both hit r: cnt unchanged (net zero); no overflow is flagged.
  - ZERO_REG and r==0: cnt[0] is held at 0.
- rd_busy[p] = (cnt[a] != 0), with one exception: when BYPASS=1 and wr_en hits a with cnt[a]==1, rd_busy[p] = 0, because the last pending value is being forwarded. An iss in the same cycle does not affect rd_busy; it takes effect next cycle.
- ovf is sticky and is cleared only by reset.
- Reset mid-operation: all pending state is discarded and the array is reinitialised; any in-flight write in that cycle is lost.

Decomposition:
- Shared package regfile_pkg holds: INIT_MODE encodings (INIT_ZERO=0, INIT_PATTERN=1), the init-value function init_val(i, DEPTH), and the default widths.
- Natural sub-module: regfile_scoreboard. It contains the counter array, the ovf flag and the busy lookup for NUM_RD ports. The parent holds the storage array, the read mux and the bypass logic.

Test Plan:
- Reset with INIT_MODE=1, DEPTH=32, then read ports at 5 and 31 -> rd_data 51 and 10; rd_busy 0; ovf 0.
- wr_en, wr_addr=7, wr_data=0xDEADBEEF, with rd_addr0=7 in the same cycle -> rd_data0 0xDEADBEEF with BYPASS=1, old value with BYPASS=0; the next cycle reads 0xDEADBEEF in both builds.
- Write 0x1234 to reg 0 with ZERO_REG=1, and issue reg 0 -> reg 0 reads 0; rd_busy 0; array unchanged.
- iss reg 3 three times (cnt=3), then a fourth time -> ovf=1 and cnt stays 3. Three writes to reg 3 -> rd_busy drops to 0 in the cycle of the third write (BYPASS=1).
- iss and wr to reg 9 in the same cycle with cnt=1 -> cnt stays 1, rd_busy remains 1 the next cycle, reg 9 holds the new data.
- Pending cnt[4]=2 and reg 4 written, then reset asserted -> the next cycle shows cnt 0, rd_busy 0, ovf 0 and reg 4 at its init value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared encodings, default widths and reset-pattern helper for regfile_mp
package regfile_pkg;
  localparam int INIT_ZERO = 0;
  localparam int INIT_PATTERN = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_CNT_W = 2;
  function automatic logic [31:0] init_val(input int i, input int depth);
    return (i < depth - 2) ? 32'(10 * i + 1) : (i == depth - 2) ? 32'd0 : 32'd10;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters, sticky overflow and per-port busy lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     ovf
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (ZERO_REG != 0 && r == 0)
        cnt_d[r] = '0;
      else if (iss_en && iss_addr == ADDR_W'(r) && !(wr_en && wr_addr == ADDR_W'(r))) begin
        if (cnt_q[r] == CNT_MAX) ovf_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (wr_en && wr_addr == ADDR_W'(r) && !(iss_en && iss_addr == ADDR_W'(r)) && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    // the final pending value is forwarded this cycle, so the reader need not stall
    assign rd_busy[p] = cnt_q[a] != '0 &&
                        !(BYPASS != 0 && wr_en && wr_addr == a && cnt_q[a] == CNT_W'(1));
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with optional bypass, zero register and pending-write scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  parameter int INIT_MODE = INIT_ZERO,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     ovf
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= ((ZERO_REG != 0 && i == 0) || INIT_MODE == INIT_ZERO) ? '0 : DATA_W'(init_val(i, DEPTH));
    end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0))
      mem_q[wr_addr] <= wr_data;
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic zero, fwd;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && a == '0;
    assign fwd = BYPASS != 0 && wr_en && wr_addr == a;
    assign rd_data[p*DATA_W +: DATA_W] = zero ? '0 : fwd ? wr_data : mem_q[a];
  end
  regfile_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy), .ovf(ovf)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two configurations (pattern init + bypass, zero init + no bypass) against a behavioural model
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] rd_addr = '0;
  logic wr_en = 1'b0, iss_en = 1'b0;
  logic [4:0] wr_addr = '0, iss_addr = '0;
  logic [31:0] wr_data = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0] rd_busy_a, rd_busy_b;
  logic ovf_a, ovf_b;
  int checks = 0, fails = 0;
  logic [31:0] mem_pat [32];
  logic [31:0] mem_zero [32];
  int cnt [32];
  bit ovf_m;
  bit model_valid = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .ovf(ovf_a));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .INIT_MODE(0), .CNT_W(2)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .ovf(ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit pat, input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (pat && wr_en && wr_addr == a) return wr_data;
    return pat ? mem_pat[a] : mem_zero[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (byp && wr_en && wr_addr == a && cnt[a] == 1) return 1'b0;
    return cnt[a] != 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_pat[i] = (i == 0) ? 0 : (i < 30) ? 10 * i + 1 : (i == 30) ? 0 : 10;
        mem_zero[i] = 0;
        cnt[i] = 0;
      end
      ovf_m = 0;
      model_valid = 1;
    end else if (model_valid) begin
      bit ih, wh;
      ih = iss_en && iss_addr != 0;
      wh = wr_en && wr_addr != 0;
      if (!(ih && wh && iss_addr == wr_addr)) begin
        if (ih) begin
          if (cnt[iss_addr] == 3) ovf_m = 1;
          else cnt[iss_addr]++;
        end
        if (wh && cnt[wr_addr] > 0) cnt[wr_addr]--;
      end
      if (wh) begin
        mem_pat[wr_addr] = wr_data;
        mem_zero[wr_addr] = wr_data;
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (model_valid) begin
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        chk($sformatf("model_rd_a%0d", p), rd_data_a[p*32 +: 32], exp_rd(1, a));
        chk($sformatf("model_rd_b%0d", p), rd_data_b[p*32 +: 32], exp_rd(0, a));
        chk($sformatf("model_busy_a%0d", p), 32'(rd_busy_a[p]), 32'(exp_busy(1, a)));
        chk($sformatf("model_busy_b%0d", p), 32'(rd_busy_b[p]), 32'(exp_busy(0, a)));
      end
      chk("model_ovf_a", 32'(ovf_a), 32'(ovf_m));
      chk("model_ovf_b", 32'(ovf_b), 32'(ovf_m));
    end
  end

  task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ia, input logic rst);
    @(negedge clk);
    #1;
    rd_addr = {ra1, ra0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; reset = rst;
    #2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(5, 31, 0, 0, 0, 0, 0, 0);
    chk("init_rd5", rd_data_a[31:0], 32'd51);
    chk("init_rd31", rd_data_a[63:32], 32'd10);
    chk("init_zero_rd5", rd_data_b[31:0], 32'd0);
    chk("init_busy", 32'(rd_busy_a), 32'd0);
    chk("init_ovf", 32'(ovf_a), 32'd0);
    drive(7, 7, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    chk("bypass_on", rd_data_a[31:0], 32'hDEADBEEF);
    chk("bypass_off_old", rd_data_b[31:0], 32'd0);
    drive(7, 7, 0, 0, 0, 0, 0, 0);
    chk("wr7_next_a", rd_data_a[31:0], 32'hDEADBEEF);
    chk("wr7_next_b", rd_data_b[31:0], 32'hDEADBEEF);
    drive(0, 0, 1, 0, 32'h1234, 1, 0, 0);
    chk("zero_wr_bypass", rd_data_a[31:0], 32'd0);
    drive(0, 5, 0, 0, 0, 0, 0, 0);
    chk("zero_rd", rd_data_a[31:0], 32'd0);
    chk("zero_busy", 32'(rd_busy_a[0]), 32'd0);
    chk("zero_ovf", 32'(ovf_a), 32'd0);
    chk("zero_array_rd5", rd_data_a[63:32], 32'd51);
    repeat (3) drive(3, 3, 0, 0, 0, 1, 3, 0);
    drive(3, 3, 0, 0, 0, 1, 3, 0);
    chk("sat_busy", 32'(rd_busy_a[0]), 32'd1);
    chk("sat_ovf_before", 32'(ovf_a), 32'd0);
    drive(3, 3, 1, 3, 32'h33, 0, 0, 0);
    chk("sat_ovf_after", 32'(ovf_a), 32'd1);
    chk("wr3_1_busy", 32'(rd_busy_a[0]), 32'd1);
    drive(3, 3, 1, 3, 32'h34, 0, 0, 0);
    chk("wr3_2_busy", 32'(rd_busy_a[0]), 32'd1);
    drive(3, 3, 1, 3, 32'h35, 0, 0, 0);
    chk("wr3_3_busy_byp", 32'(rd_busy_a[0]), 32'd0);
    chk("wr3_3_busy_nobyp", 32'(rd_busy_b[0]), 32'd1);
    drive(3, 3, 0, 0, 0, 0, 0, 0);
    chk("wr3_after_busy", 32'(rd_busy_b[0]), 32'd0);
    chk("wr3_after_data", rd_data_b[31:0], 32'h35);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    drive(9, 9, 0, 0, 0, 1, 9, 0);
    drive(9, 9, 1, 9, 32'h99, 1, 9, 0);
    drive(9, 9, 0, 0, 0, 0, 0, 0);
    chk("isswr9_busy", 32'(rd_busy_a[0]), 32'd1);
    chk("isswr9_data", rd_data_a[31:0], 32'h99);
    drive(4, 4, 0, 0, 0, 1, 4, 0);
    drive(4, 4, 0, 0, 0, 1, 4, 0);
    drive(4, 4, 1, 4, 32'h44, 0, 0, 0);
    drive(4, 4, 1, 4, 32'h55, 0, 0, 1);
    drive(4, 4, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(rd_busy_a[0]), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_rd4_a", rd_data_a[31:0], 32'd41);
    chk("rst_rd4_b", rd_data_b[31:0], 32'd0);
    for (int n = 0; n < 600; n++)
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
            $urandom_range(0, 63) == 0);
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
